debouncer: RTL and testbench
============================

// Module: debouncer
// PURPOSE
//   Per-bit debouncer plus rising-edge pulse generator for mechanical inputs
//   (buttons, switches). Sits directly downstream of the 2-FF synchronizer:
//   consumes its already-synchronized, still-bouncy bits and produces clean
//   levels plus single-cycle press pulses for the FSM/control logic.
//   One shared sample timer serves all bits; each bit has its own counter.
// PARAMETERS
//   WIDTH           1        number of independent input bits
//   SAMPLE_CNT_MAX  25000    clk cycles per sample tick (>= 2)
//   PULSE_CNT_MAX   150      consecutive high samples needed to assert (>= 1)
// PORTS
//   clk               input   1      system clock, all state on posedge
//   rst_n             input   1      async active-low reset
//   glitchy_signal    input   WIDTH  synchronized, bouncy level per bit
//   debounced_signal  output  WIDTH  clean level per bit
//   press_pulse       output  WIDTH  1-cycle pulse on each debounced rise
// BEHAVIOUR
//   Reset (rst_n low, async, any time incl. mid-count): sample counter=0, all
//     per-bit counters=0, edge-history reg=0; debounced_signal=0,
//     press_pulse=0 immediately. Counting restarts from 0 after rst_n rises.
//   Sample timer: width $clog2(SAMPLE_CNT_MAX); counts 0..SAMPLE_CNT_MAX-1,
//     wraps to 0. sample_tick=1 combinationally while count==SAMPLE_CNT_MAX-1
//     (one cycle in every SAMPLE_CNT_MAX). Free-running, bit-independent.
//   Per-bit saturating counter cnt[i], width $clog2(PULSE_CNT_MAX+1):
//     - glitchy_signal[i]==0 on any cycle -> cnt[i] <= 0 (no tick needed).
//     - glitchy_signal[i]==1 and sample_tick and cnt[i]<PULSE_CNT_MAX
//       -> cnt[i] <= cnt[i]+1.
//     - cnt[i]==PULSE_CNT_MAX -> holds (saturates, never wraps).
//     - low and tick in same cycle: clear wins.
//   debounced_signal[i] = (cnt[i]==PULSE_CNT_MAX); decoded from registered
//     state only, no input-to-output combinational path.
//   Release: first cycle input bit is 0 -> cnt cleared at next edge ->
//     debounced drops 1 cycle after input falls (release is not filtered).
//   Edge detect: prev[i] <= debounced_signal[i] each cycle;
//     press_pulse[i] = debounced_signal[i] & ~prev[i]; exactly one cycle wide,
//     coincident with first high cycle of debounced_signal[i]. No pulse on fall.
//   Assert latency: input held high continuously needs PULSE_CNT_MAX ticks;
//     worst case SAMPLE_CNT_MAX*PULSE_CNT_MAX cycles, best case
//     (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX+1 cycles.
//   Bits are fully independent; simultaneous presses give simultaneous pulses.
// TESTING (SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, WIDTH=2 unless noted)
//   1 Reset release with inputs 2'b01 held -> bit0 debounced high after
//     exactly 12 posedges, press_pulse=2'b01 for that 1 cycle only; bit1 stays 0.
//   2 Bounce: bit0 high 10 cycles, low 1 cycle, high again -> cnt cleared,
//     debounced stays 0 until 3 further ticks of uninterrupted high.
//   3 Held high 100 cycles after assert -> debounced stays 1, cnt saturates
//     at 3, press_pulse never reasserts; drop input -> debounced 0 next cycle.
//   4 Both bits driven high same cycle -> both debounce same cycle,
//     press_pulse=2'b11 for one cycle.
//   5 rst_n pulsed low mid-count (cnt=2) and after assert -> outputs 0
//     without waiting for clk; full 12-cycle latency required again.
//   6 Input low exactly on tick cycle -> cnt reads 0 afterwards (clear wins).

Source files
------------

// File: rtl/debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
//
// Per-bit debouncer with rising-edge pulse generation for mechanical inputs
// (buttons, switches). The inputs are expected to be already synchronized to
// clk (2-FF synchronizer upstream) but may still bounce.
//
// One free-running sample timer is shared by all bits. It produces a
// single-cycle sample tick every SAMPLE_CNT_MAX clocks. Each bit owns a
// saturating counter:
//   - the counter clears on any cycle the bit is low (no tick needed),
//   - it increments on a tick while the bit is high,
//   - it holds once it reaches PULSE_CNT_MAX.
// A bit is debounced high while its counter is saturated, so a press is
// filtered but a release takes effect one cycle after the input falls.
//
// A one-cycle press pulse marks the first high cycle of each debounced bit.
// There is no pulse on release.
//
// Parameters
//   WIDTH           number of independent input bits
//   SAMPLE_CNT_MAX  clk cycles per sample tick (>= 2)
//   PULSE_CNT_MAX   consecutive high samples needed to assert (>= 1)
//
// Ports
//   clk               in   1      system clock, all state on posedge
//   rst_n             in   1      asynchronous active-low reset
//   glitchy_signal    in   WIDTH  synchronized, bouncy level per bit
//   debounced_signal  out  WIDTH  clean level per bit
//   press_pulse       out  WIDTH  1-cycle pulse on each debounced rise
// -----------------------------------------------------------------------------
module debouncer #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 150
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] press_pulse
);

    // Sample timer width covers 0..SAMPLE_CNT_MAX-1; counter width covers
    // 0..PULSE_CNT_MAX inclusive so saturation is representable.
    localparam int SCW = $clog2(SAMPLE_CNT_MAX);
    localparam int PCW = $clog2(PULSE_CNT_MAX + 1);

    localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_CNT_MAX - 1);
    localparam logic [PCW-1:0] PULSE_SAT   = PCW'(PULSE_CNT_MAX);

    // -------------------------------------------------------------------------
    // Shared sample timer
    // -------------------------------------------------------------------------
    logic [SCW-1:0] sample_cnt_q;
    logic [SCW-1:0] sample_cnt_d;
    logic           sample_tick;

    // The tick is high for the whole cycle the timer sits on its last value,
    // so the increment it enables lands on the same edge the timer wraps.
    assign sample_tick = (sample_cnt_q == SAMPLE_LAST);

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves it unassigned (which would infer a latch).
        sample_cnt_d = sample_cnt_q + SCW'(1);
        if (sample_tick) begin
            sample_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // all registers sample their inputs from the same edge.
        if (!rst_n) begin
            sample_cnt_q <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Per-bit saturating counters
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0][PCW-1:0] cnt_q;
    logic [WIDTH-1:0][PCW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (!glitchy_signal[i]) begin
                // A low input clears immediately, even on a tick cycle.
                cnt_d[i] = '0;
            end else if (sample_tick && (cnt_q[i] < PULSE_SAT)) begin
                cnt_d[i] = cnt_q[i] + PCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded purely from registered state, so there is no
    // combinational path from glitchy_signal to either output.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] prev_q;

    always_comb begin
        debounced_signal = '0;
        for (int i = 0; i < WIDTH; i++) begin
            debounced_signal[i] = (cnt_q[i] == PULSE_SAT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= debounced_signal;
        end
    end

    // High only on the first cycle a bit is debounced high; a fall never
    // pulses because the term requires the current level to be 1.
    assign press_pulse = debounced_signal & ~prev_q;

endmodule

// File: tb/tb_debouncer.sv
// -----------------------------------------------------------------------------
// tb_debouncer
//
// Directed bench for debouncer with SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, WIDTH=2.
// Stimulus pushes expected {debounced, pulse} values, tagged with the absolute
// cycle they must appear on, into a scoreboard queue. A monitor on the falling
// edge pops and compares entries that fall due, and flags any press pulse that
// no entry accounts for. Asynchronous-reset behaviour is checked directly
// between clock edges.
//
// Timing reference: after reset is released on a falling edge, the cycle
// count at that edge is the base; the state seen at the falling edge of
// base+k reflects k rising edges. Timer increments land on edges 4, 8, 12...
// -----------------------------------------------------------------------------
module tb_debouncer;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] glitchy_signal = '0;
    logic [W-1:0] debounced_signal;
    logic [W-1:0] press_pulse;

    debouncer #(
        .WIDTH          (W),
        .SAMPLE_CNT_MAX (4),
        .PULSE_CNT_MAX  (3)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .glitchy_signal   (glitchy_signal),
        .debounced_signal (debounced_signal),
        .press_pulse      (press_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] deb;
        logic [1:0] pls;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
        end
    endtask

    task automatic expect_at(input int c, input logic [1:0] d, input logic [1:0] p,
                             input string tag);
        exp_t e;
        e.cyc = c;
        e.deb = d;
        e.pls = p;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic release_reset(output int base);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = cyc;
    endtask

    // Monitor: compares due entries and catches pulses nobody expected.
    always @(negedge clk) begin
        exp_t e;
        bit   seen;
        seen = 1'b0;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            seen = 1'b1;
            check(e.tag, int'({debounced_signal, press_pulse}), int'({e.deb, e.pls}));
        end
        if (press_pulse != '0 && !seen) begin
            check("unexpected_pulse", int'(press_pulse), 0);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: stimulus did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int b;

        // Reset state while rst_n is held low.
        #3;
        check("reset_state", int'({debounced_signal, press_pulse}), 0);

        // Reset release with bit0 held high, then hold 100 cycles, then drop.
        glitchy_signal = 2'b01;
        release_reset(b);
        expect_at(b + 11, 2'b00, 2'b00, "t1_before_assert");
        expect_at(b + 12, 2'b01, 2'b01, "t1_assert");
        for (int k = 13; k <= 112; k++) expect_at(b + k, 2'b01, 2'b00, "t3_hold");
        wait_cyc(b + 112);
        glitchy_signal = 2'b00;
        expect_at(b + 113, 2'b00, 2'b00, "t3_release");
        expect_at(b + 114, 2'b00, 2'b00, "t3_release_stays");
        wait_cyc(b + 114);

        // Bounce: high 10 cycles, low 1 cycle, then high again.
        glitchy_signal = 2'b01;
        release_reset(b);
        expect_at(b + 12, 2'b00, 2'b00, "t2_cleared");
        expect_at(b + 19, 2'b00, 2'b00, "t2_before_assert");
        expect_at(b + 20, 2'b01, 2'b01, "t2_assert");
        expect_at(b + 21, 2'b01, 2'b00, "t2_after_assert");
        wait_cyc(b + 10);
        glitchy_signal = 2'b00;
        wait_cyc(b + 11);
        glitchy_signal = 2'b01;
        wait_cyc(b + 21);

        // Input low exactly on the tick cycle before edge 12: clear wins.
        glitchy_signal = 2'b01;
        release_reset(b);
        expect_at(b + 12, 2'b00, 2'b00, "t6_clear_wins");
        expect_at(b + 23, 2'b00, 2'b00, "t6_before_assert");
        expect_at(b + 24, 2'b01, 2'b01, "t6_assert");
        wait_cyc(b + 11);
        glitchy_signal = 2'b00;
        wait_cyc(b + 12);
        glitchy_signal = 2'b01;
        wait_cyc(b + 24);

        // Both bits rise together.
        glitchy_signal = 2'b00;
        release_reset(b);
        glitchy_signal = 2'b11;
        expect_at(b + 11, 2'b00, 2'b00, "t4_before_assert");
        expect_at(b + 12, 2'b11, 2'b11, "t4_assert_both");
        expect_at(b + 13, 2'b11, 2'b00, "t4_after_assert");
        wait_cyc(b + 13);

        // Async reset mid-count (counter at 2).
        glitchy_signal = 2'b01;
        release_reset(b);
        wait_cyc(b + 9);
        #2 rst_n = 1'b0;
        #1 check("t5_async_mid_count", int'({debounced_signal, press_pulse}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        b = cyc;
        expect_at(b + 11, 2'b00, 2'b00, "t5_restart_before");
        expect_at(b + 12, 2'b01, 2'b01, "t5_restart_assert");
        expect_at(b + 13, 2'b01, 2'b00, "t5_restart_after");
        wait_cyc(b + 13);

        // Async reset after assert: outputs drop without a clock edge.
        #2 rst_n = 1'b0;
        #1 check("t5_async_after_assert", int'({debounced_signal, press_pulse}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        b = cyc;
        expect_at(b + 11, 2'b00, 2'b00, "t5_relatch_before");
        expect_at(b + 12, 2'b01, 2'b01, "t5_relatch_assert");
        wait_cyc(b + 13);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
